// File: rtl/acl_spi_ctrl_if.sv
// SPI pin bundle between the accelerometer controller (master) and the ADXL362 (slave).
interface acl_spi_ctrl_if;
    logic sclk;
    logic mosi;
    logic miso;
    logic cs_n;

    modport master (output sclk, output mosi, output cs_n, input miso);
    modport slave  (input sclk, input mosi, input cs_n, output miso);
endinterface

// File: rtl/acl_spi_ctrl.sv
// ADXL362 sequencer: one-shot POWER_CTL write after reset, then periodic X/Y/Z burst reads
// over a mode-0 SPI link clocked from a half-period counter on the system clock.
module acl_spi_ctrl #(
    parameter int HALF_PERIOD   = 12,
    parameter int STARTUP_WAIT  = 600000,
    parameter int SAMPLE_PERIOD = 1000000,
    parameter int CS_GAP        = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    acl_spi_ctrl_if.master    spi,
    output logic [11:0]       acl_x,
    output logic [11:0]       acl_y,
    output logic [11:0]       acl_z,
    output logic              sample_valid,
    output logic              cfg_done,
    output logic              busy
);

    localparam logic [2:0] ST_BOOT   = 3'd0;
    localparam logic [2:0] ST_CFG    = 3'd1;
    localparam logic [2:0] ST_GAP    = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_READ   = 3'd4;
    localparam logic [2:0] ST_UPDATE = 3'd5;

    localparam logic [1:0] PH_SETUP = 2'd0;
    localparam logic [1:0] PH_LOW   = 2'd1;
    localparam logic [1:0] PH_HIGH  = 2'd2;
    localparam logic [1:0] PH_HOLD  = 2'd3;

    localparam int HW    = $clog2(HALF_PERIOD + 1);
    localparam int TW    = $clog2(SAMPLE_PERIOD + 1);
    localparam int CMAX  = (STARTUP_WAIT > CS_GAP) ? STARTUP_WAIT : CS_GAP;
    localparam int CW    = $clog2(CMAX + 1);

    logic [2:0]    state_r;
    logic [1:0]    phase_r;
    logic [HW-1:0] half_r;
    logic [5:0]    bit_r;
    logic [CW-1:0] cnt_r;
    logic [TW-1:0] timer_r;
    logic          timer_run_r;
    logic          sclk_r;
    logic          mosi_r;
    logic          cs_n_r;
    logic          cfg_done_r;
    logic [47:0]   shadow_r;
    logic [11:0]   acl_x_r;
    logic [11:0]   acl_y_r;
    logic [11:0]   acl_z_r;
    logic          sample_valid_r;

    logic          expire_s;
    logic          start_read_s;
    logic          half_end_s;
    logic [5:0]    last_bit_s;

    // Command byte stream: byte index from idx[5:3], MSB first within each byte
    function automatic logic tx_bit(input logic is_read, input logic [5:0] idx);
        logic [7:0] byte_s;
        byte_s = 8'h00;
        case (idx[5:3])
            3'd0:    byte_s = is_read ? 8'h0B : 8'h0A;
            3'd1:    byte_s = is_read ? 8'h0E : 8'h2D;
            3'd2:    byte_s = is_read ? 8'h00 : 8'h02;
            default: byte_s = 8'h00;
        endcase
        return byte_s[3'd7 - idx[2:0]];
    endfunction

    // Timer expiry, read launch decision and per-transaction bit limits
    always_comb begin
        expire_s     = timer_run_r && (timer_r == TW'(SAMPLE_PERIOD - 1));
        start_read_s = (state_r == ST_WAIT) && enable && (!timer_run_r || expire_s);
        half_end_s   = (half_r == HW'(HALF_PERIOD - 1));
        last_bit_s   = (state_r == ST_READ) ? 6'd63 : 6'd23;
    end

    // Sample timer: free-running from the first READ start so the read cadence stays exact
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_r     <= '0;
            timer_run_r <= 1'b0;
        end else if (start_read_s) begin
            timer_r     <= '0;
            timer_run_r <= 1'b1;
        end else if (timer_run_r) begin
            timer_r     <= expire_s ? '0 : timer_r + TW'(1);
        end else begin
            timer_r     <= timer_r;
        end
    end

    // Sequencer and SPI bit engine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_BOOT;
            phase_r    <= PH_SETUP;
            half_r     <= '0;
            bit_r      <= 6'd0;
            cnt_r      <= '0;
            sclk_r     <= 1'b0;
            mosi_r     <= 1'b0;
            cs_n_r     <= 1'b1;
            cfg_done_r <= 1'b0;
            shadow_r   <= 48'h0;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    if (cnt_r == CW'(STARTUP_WAIT - 1)) begin
                        cnt_r   <= '0;
                        state_r <= ST_CFG;
                        cs_n_r  <= 1'b0;
                        mosi_r  <= tx_bit(1'b0, 6'd0);
                        half_r  <= '0;
                        phase_r <= PH_SETUP;
                        bit_r   <= 6'd0;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_CFG, ST_READ: begin
                    if (!half_end_s) begin
                        half_r <= half_r + HW'(1);
                    end else begin
                        half_r <= '0;
                        case (phase_r)
                            PH_SETUP: phase_r <= PH_LOW;
                            PH_LOW: begin
                                phase_r <= PH_HIGH;
                                sclk_r  <= 1'b1;
                                // Bytes 2..7 of a read carry XL..ZH; earlier bytes are command echo
                                if (state_r == ST_READ && bit_r[5:4] != 2'b00) begin
                                    shadow_r <= {shadow_r[46:0], spi.miso};
                                end
                            end
                            PH_HIGH: begin
                                sclk_r <= 1'b0;
                                if (bit_r == last_bit_s) begin
                                    phase_r <= PH_HOLD;
                                    mosi_r  <= 1'b0;
                                end else begin
                                    phase_r <= PH_LOW;
                                    bit_r   <= bit_r + 6'd1;
                                    mosi_r  <= tx_bit(state_r == ST_READ, bit_r + 6'd1);
                                end
                            end
                            PH_HOLD: begin
                                cs_n_r <= 1'b1;
                                if (state_r == ST_CFG) begin
                                    cfg_done_r <= 1'b1;
                                    state_r    <= ST_GAP;
                                end else begin
                                    state_r    <= ST_UPDATE;
                                end
                            end
                            default: phase_r <= PH_SETUP;
                        endcase
                    end
                end
                ST_UPDATE: state_r <= ST_GAP;
                ST_GAP: begin
                    if (cnt_r == CW'(CS_GAP - 1)) begin
                        cnt_r   <= '0;
                        state_r <= ST_WAIT;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_WAIT: begin
                    if (start_read_s) begin
                        state_r <= ST_READ;
                        cs_n_r  <= 1'b0;
                        mosi_r  <= tx_bit(1'b1, 6'd0);
                        half_r  <= '0;
                        phase_r <= PH_SETUP;
                        bit_r   <= 6'd0;
                    end
                end
                default: state_r <= ST_BOOT;
            endcase
        end
    end

    // Published samples change only in UPDATE, so a partial capture never escapes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acl_x_r        <= 12'h000;
            acl_y_r        <= 12'h000;
            acl_z_r        <= 12'h000;
            sample_valid_r <= 1'b0;
        end else begin
            sample_valid_r <= (state_r == ST_UPDATE);
            if (state_r == ST_UPDATE) begin
                acl_x_r <= {shadow_r[35:32], shadow_r[47:40]};
                acl_y_r <= {shadow_r[19:16], shadow_r[31:24]};
                acl_z_r <= {shadow_r[3:0],   shadow_r[15:8]};
            end
        end
    end

    assign spi.sclk     = sclk_r;
    assign spi.mosi     = mosi_r;
    assign spi.cs_n     = cs_n_r;
    assign acl_x        = acl_x_r;
    assign acl_y        = acl_y_r;
    assign acl_z        = acl_z_r;
    assign sample_valid = sample_valid_r;
    assign cfg_done     = cfg_done_r;
    assign busy         = ~cs_n_r;

endmodule

// File: tb/tb_acl_spi_ctrl.sv
// Directed bench for acl_spi_ctrl with an ADXL362-like SPI slave model and framing monitor.
module tb_acl_spi_ctrl;
    localparam int HP = 2;
    localparam int SW = 10;
    localparam int SP = 300;
    localparam int CG = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [11:0] acl_x;
    logic [11:0] acl_y;
    logic [11:0] acl_z;
    logic        sample_valid;
    logic        cfg_done;
    logic        busy;

    acl_spi_ctrl_if spi ();

    acl_spi_ctrl #(
        .HALF_PERIOD(HP), .STARTUP_WAIT(SW), .SAMPLE_PERIOD(SP), .CS_GAP(CG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .spi(spi),
        .acl_x(acl_x), .acl_y(acl_y), .acl_z(acl_z),
        .sample_valid(sample_valid), .cfg_done(cfg_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    // Slave/monitor state
    logic [63:0] tx64;
    logic [63:0] rx64 = 64'h0;
    logic [63:0] last_rx = 64'h0;
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b0;
    logic        prev_mosi = 1'b0;
    logic        cfg_at_fall = 1'b0;
    int fall_cyc = 0, rise_cyc = 0, bitn = 0, last_bits = 0, trans_done = 0;
    int sv_cyc = 0, sv_run = 0, sv_max = 0;
    int busy_err = 0, edge_err = 0, mosi_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: shift mosi on sclk rise, present miso on cs_n fall and sclk fall
    always @(negedge clk) begin
        prev_cs   <= spi.cs_n;
        prev_sclk <= spi.sclk;
        prev_mosi <= spi.mosi;
        if (busy !== ~spi.cs_n) busy_err <= busy_err + 1;
        if (spi.cs_n === 1'b1 && spi.sclk !== prev_sclk) edge_err <= edge_err + 1;
        if (spi.sclk === 1'b1 && spi.mosi !== prev_mosi) mosi_err <= mosi_err + 1;
        if (prev_cs && !spi.cs_n) begin
            fall_cyc    <= cyc;
            bitn        <= 0;
            rx64        <= 64'h0;
            spi.miso    <= tx64[63];
            cfg_at_fall <= cfg_done;
        end else if (!spi.cs_n && spi.sclk && !prev_sclk) begin
            rx64 <= {rx64[62:0], spi.mosi};
            bitn <= bitn + 1;
        end else if (!spi.cs_n && !spi.sclk && prev_sclk) begin
            spi.miso <= (bitn < 64) ? tx64[63 - bitn] : 1'b0;
        end
        if (!prev_cs && spi.cs_n) begin
            rise_cyc   <= cyc;
            last_bits  <= bitn;
            last_rx    <= rx64;
            trans_done <= trans_done + 1;
        end
        if (sample_valid) begin
            sv_cyc <= cyc;
            sv_run <= sv_run + 1;
            if (sv_run + 1 > sv_max) sv_max <= sv_run + 1;
        end else begin
            sv_run <= 0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_trans(input string tag);
        int start_n;
        int i;
        start_n = trans_done;
        i = 0;
        while (trans_done == start_n && i < 2000) begin
            tick();
            i++;
        end
        chk({tag, "_timeout"}, 64'(trans_done != start_n), 64'd1);
    endtask

    initial begin
        int c0;
        int f_prev;
        int s_prev;
        int n;
        int i;
        rst_n  = 1'b0;
        enable = 1'b1;
        tx64   = {16'h0000, 8'h34, 8'hF1, 8'hFF, 8'h0F, 8'h00, 8'h08};
        repeat (3) tick();

        chk("rst_cs_n", 64'(spi.cs_n), 64'd1);
        chk("rst_sclk", 64'(spi.sclk), 64'd0);
        chk("rst_mosi", 64'(spi.mosi), 64'd0);
        chk("rst_acl", {28'h0, acl_x, acl_y, acl_z}, 64'h0);
        chk("rst_flags", {61'h0, sample_valid, cfg_done, busy}, 64'h0);

        // Configuration write after power-up wait
        c0 = cyc;
        rst_n = 1'b1;
        wait_trans("cfg");
        chk("cfg_start_delay", 64'(fall_cyc - c0), 64'd10);
        chk("cfg_bits", 64'(last_bits), 64'd24);
        chk("cfg_bytes", last_rx, 64'h0A2D02);
        chk("cfg_len", 64'(rise_cyc - fall_cyc), 64'd100);
        chk("cfg_done_during", 64'(cfg_at_fall), 64'd0);
        chk("cfg_done_after", 64'(cfg_done), 64'd1);

        // First read
        wait_trans("read1");
        tick(); tick();
        chk("read1_bits", 64'(last_bits), 64'd64);
        chk("read1_bytes", last_rx, 64'h0B0E000000000000);
        chk("read1_len", 64'(rise_cyc - fall_cyc), 64'd260);
        chk("read1_sv_delay", 64'(sv_cyc - rise_cyc), 64'd1);
        chk("read1_x", 64'(acl_x), 64'h134);
        chk("read1_y", 64'(acl_y), 64'hFFF);
        chk("read1_z", 64'(acl_z), 64'h800);

        // Periodicity with fresh data each read
        f_prev = fall_cyc;
        s_prev = sv_cyc;
        tx64 = {16'h0000, 8'h00, 8'h07, 8'hAB, 8'h35, 8'h01, 8'hF0};
        wait_trans("read2");
        tick(); tick();
        chk("read2_period", 64'(fall_cyc - f_prev), 64'd300);
        chk("read2_sv_period", 64'(sv_cyc - s_prev), 64'd300);
        chk("read2_xyz", {28'h0, acl_x, acl_y, acl_z}, {28'h0, 12'h700, 12'h5AB, 12'h001});

        f_prev = fall_cyc;
        s_prev = sv_cyc;
        tx64 = {16'h0000, 8'hFF, 8'h07, 8'h00, 8'hF8, 8'h5A, 8'h0C};
        wait_trans("read3");
        tick(); tick();
        chk("read3_period", 64'(fall_cyc - f_prev), 64'd300);
        chk("read3_sv_period", 64'(sv_cyc - s_prev), 64'd300);
        chk("read3_xyz", {28'h0, acl_x, acl_y, acl_z}, {28'h0, 12'h7FF, 12'h800, 12'hC5A});

        // Enable gating: skip one slot
        enable = 1'b0;
        f_prev = fall_cyc;
        tx64 = {16'h0000, 8'h34, 8'hF1, 8'hFF, 8'h0F, 8'h00, 8'h08};
        n = trans_done;
        i = 0;
        while (cyc < f_prev + 450 && i < 1000) begin
            tick();
            i++;
        end
        chk("gate_no_txn", 64'(trans_done), 64'(n));
        chk("gate_cs_idle", 64'(spi.cs_n), 64'd1);
        chk("gate_hold_xyz", {28'h0, acl_x, acl_y, acl_z}, {28'h0, 12'h7FF, 12'h800, 12'hC5A});
        enable = 1'b1;
        wait_trans("read4");
        tick(); tick();
        chk("read4_period", 64'(fall_cyc - f_prev), 64'd600);
        chk("read4_x", 64'(acl_x), 64'h134);

        // Reset in the low phase of bit 30 of the next read
        i = 0;
        while (!(bitn == 30 && spi.cs_n === 1'b0 && spi.sclk === 1'b0) && i < 1000) begin
            tick();
            i++;
        end
        chk("bit30_reached", 64'(i < 1000), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_cs_n", 64'(spi.cs_n), 64'd1);
        chk("midrst_sclk", 64'(spi.sclk), 64'd0);
        chk("midrst_acl", {28'h0, acl_x, acl_y, acl_z}, 64'h0);
        chk("midrst_flags", {61'h0, sample_valid, cfg_done, busy}, 64'h0);
        repeat (3) tick();
        c0 = cyc;
        rst_n = 1'b1;
        wait_trans("recfg");
        chk("recfg_start_delay", 64'(fall_cyc - c0), 64'd10);
        chk("recfg_bits", 64'(last_bits), 64'd24);
        chk("recfg_bytes", last_rx, 64'h0A2D02);
        wait_trans("read_after_rst");
        tick(); tick();
        chk("read_after_rst_bits", 64'(last_bits), 64'd64);
        chk("read_after_rst_xyz", {28'h0, acl_x, acl_y, acl_z}, {28'h0, 12'h134, 12'hFFF, 12'h800});

        // Whole-run framing properties
        chk("sclk_edge_while_cs_high", 64'(edge_err), 64'd0);
        chk("mosi_change_while_sclk_high", 64'(mosi_err), 64'd0);
        chk("busy_vs_cs_n", 64'(busy_err), 64'd0);
        chk("sample_valid_width", 64'(sv_max), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/acl_spi_ctrl.md
Name: acl_spi_ctrl

Overview:
- SPI master and sequencer for the on-board ADXL362 accelerometer.
- Once after reset, writes POWER_CTL to enter measurement mode. Then burst-reads X/Y/Z every SAMPLE_PERIOD system clocks and presents registered 12-bit signed samples to the game-control logic.
- Generates SCLK internally from a half-period counter on the 100 MHz system clock; no derived clock domain.

Parameters:
- HALF_PERIOD, 12: system clocks per SCLK half-period (100 MHz / 24 ≈ 4.17 MHz; must be ≥2).
- STARTUP_WAIT, 600000: clocks held idle after reset before configuration (6 ms device power-up).
- SAMPLE_PERIOD, 1000000: clocks between read-transaction starts (10 ms).
- CS_GAP, 20: minimum clocks cs_n stays high between transactions.

Ports:
- clk  in  1  100 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  periodic sampling allowed when high
- miso  in  1  SPI data from device
- sclk  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
- mosi  out  1  SPI data to device, MSB first
- cs_n  out  1  SPI chip select, active low
- acl_x  out  12  X sample, two's complement
- acl_y  out  12  Y sample, two's complement
- acl_z  out  12  Z sample, two's complement
- sample_valid  out  1  one-cycle pulse when acl_x/y/z update
- cfg_done  out  1  high once the configuration write has completed
- busy  out  1  high while cs_n is low

Behaviour:
- Reset (async, rst_n=0):
  - sclk=0, mosi=0, cs_n=1.
  - acl_x/y/z=0, sample_valid=0, cfg_done=0, busy=0.
  - All counters=0, state=BOOT.
- FSM states: BOOT, CFG, GAP, WAIT, READ, UPDATE.
  - BOOT: count STARTUP_WAIT clocks, then go to CFG.
  - CFG: 3-byte write transaction 0x0A, 0x2D, 0x02. At end, cfg_done<=1 (sticky until reset), then go to GAP.
  - GAP: cs_n high for CS_GAP clocks, then go to WAIT.
  - WAIT: sample timer runs continuously from the first READ start, independent of enable.
    - On timer expiry with enable=1, go to READ.
    - If enable=0 at expiry, skip that slot and stay in WAIT.
    - The first READ follows GAP immediately if enable=1; otherwise it waits for the next expiry with enable=1.
  - READ: 8-byte transaction 0x0B, 0x0E, then six dummy 0x00 bytes. MISO bytes 2..7 capture XL, XH, YL, YH, ZL, ZH into a shadow buffer.
  - UPDATE (1 clock): acl_x<={XH[3:0],XL}, same for Y and Z. sample_valid=1 for this clock only. Then go to GAP.
- Transaction framing:
  - cs_n falls, then HALF_PERIOD clocks of setup with sclk=0 and mosi=first bit.
  - Each bit: sclk low for HALF_PERIOD, then high for HALF_PERIOD.
  - miso is sampled on the system clock edge where sclk goes 0→1.
  - mosi changes on the sclk 1→0 transition.
  - After the last bit: sclk=0, hold HALF_PERIOD clocks, then cs_n rises.
  - Length = (2 + 16·nbytes)·HALF_PERIOD clocks of cs_n low.
- busy == ~cs_n exactly.
- Outputs only change in UPDATE. Partial captures never reach acl_*.
- sample_valid asserts on the clock after cs_n rises at the end of a READ.
- Sample timer counts SAMPLE_PERIOD from one READ start to the next. Transaction time is included, so the period is exact provided SAMPLE_PERIOD > READ length + CS_GAP + 2.
- enable deasserted during READ: the transaction completes and UPDATE occurs normally.
- Reset mid-transaction: immediate return to reset values (cs_n=1). After release, the full BOOT and CFG sequence is re-run.
- Bit counter 0..(8·nbytes−1), byte index from bits[5:3]. No wrap beyond the last bit.

Test Plan:
- Bench overrides: HALF_PERIOD=2, STARTUP_WAIT=10, SAMPLE_PERIOD=300, CS_GAP=4. Bench includes an SPI slave model.
- Config write: release reset.
  - cs_n falls 10 clocks later.
  - Slave records bytes 0x0A, 0x2D, 0x02 with exactly 24 sclk rising edges.
  - cs_n low for 100 clocks; cfg_done rises after cs_n rises.
- First read: slave returns XL=0x34, XH=0xF1, YL=0xFF, YH=0x0F, ZL=0x00, ZH=0x08.
  - Master sends 0x0B, 0x0E, then 0x00 ×6; cs_n low for 260 clocks.
  - acl_x=0x134, acl_y=0xFFF, acl_z=0x800; sample_valid high exactly 1 clock after cs_n rises.
- Periodicity: run 3 reads. Consecutive cs_n falling edges of READs are exactly 300 clocks apart, and sample_valid pulses are exactly 300 clocks apart.
- Enable gating: drop enable for one slot.
  - No cs_n activity during that slot; acl_* hold their values.
  - Re-raise enable: the next READ starts on the following 300-clock boundary.
- Reset mid-READ: assert rst_n=0 at bit 30 of a READ.
  - cs_n=1, sclk=0, outputs zero, cfg_done=0 asynchronously.
  - After release, 0x0A 0x2D 0x02 is re-sent before any read.
- SPI mode check: slave model flags any mosi change while sclk=1 and any sclk edge while cs_n=1. Both counts must be 0 over the whole run.
